// File: rtl/idecode_stage_pkg.sv
// Shared definitions for the ID stage: widths, opcodes, ALU op codes and
// the control bundles that travel down the pipeline.
// Optional feature macro used by the register file: IDECODE_RF_BYPASS_EN.
package idecode_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned IMM_W      = 16;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;
    localparam opcode_t OP_BEQ   = 6'h04;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Write-back stage control: {regwrite, memtoreg}
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctl_t;

    // Memory stage control: {branch, memread, memwrite}
    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
    } m_ctl_t;

endpackage

// File: rtl/id_regfile.sv
// id_regfile: register file, 2 combinational read ports, 1 write port.
// Ports:
//   clk, rst_n           clock, async active-low clear of every entry
//   we, waddr, wdata     write port (writes to entry 0 are dropped)
//   raddr1, raddr2       read addresses
//   rdata1_c, rdata2_c   combinational read data (entry 0 reads as 0)
// Macro IDECODE_RF_BYPASS_EN: when defined, a read of the register being
// written this cycle returns the write data (write-through).
module id_regfile
    import idecode_stage_pkg::*;
#(
    parameter int unsigned DW    = DATA_W,
    parameter int unsigned AW    = REG_ADDR_W,
    parameter int unsigned DEPTH = NUM_REGS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1_c,
    output logic [DW-1:0] rdata2_c
);

    logic [DW-1:0] mem [DEPTH];
    logic          wr_en;

    assign wr_en = we && (waddr != '0);

    // Storage: cleared on reset, entry 0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports
    always_comb begin
        rdata1_c = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2_c = (raddr2 == '0) ? '0 : mem[raddr2];
`ifdef IDECODE_RF_BYPASS_EN
        if (wr_en && (waddr == raddr1)) rdata1_c = wdata;
        if (wr_en && (waddr == raddr2)) rdata2_c = wdata;
`endif
    end

endmodule

// File: rtl/idecode_stage.sv
// idecode_stage: MIPS-style instruction-decode stage feeding ID/EX.
// Decodes the opcode into WB/M/EX control, reads rs/rt from the register
// file, sign-extends imm16 and registers everything into ID/EX.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   IF_ID_instr, IF_ID_npc          instruction and PC+4 from IF/ID
//   MEM_WB_rd, MEM_WB_regwrite,
//   WB_mux5_writedata               write-back port from MEM/WB
//   wb_ctlout, m_ctlout, regdst,
//   alusrc, aluop                   registered control
//   npcout, rdata1out, rdata2out,
//   s_extendout, instrout_2016,
//   instrout_1511                   registered datapath fields
// Macro IDECODE_RF_BYPASS_EN: register-file write-through on same-cycle
// read of the register being written.
module idecode_stage
    import idecode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     IF_ID_instr,
    input  logic [DATA_W-1:0]     IF_ID_npc,
    input  logic [REG_ADDR_W-1:0] MEM_WB_rd,
    input  logic                  MEM_WB_regwrite,
    input  logic [DATA_W-1:0]     WB_mux5_writedata,
    output logic [1:0]            wb_ctlout,
    output logic [2:0]            m_ctlout,
    output logic                  regdst,
    output logic                  alusrc,
    output logic [1:0]            aluop,
    output logic [DATA_W-1:0]     npcout,
    output logic [DATA_W-1:0]     rdata1out,
    output logic [DATA_W-1:0]     rdata2out,
    output logic [DATA_W-1:0]     s_extendout,
    output logic [REG_ADDR_W-1:0] instrout_2016,
    output logic [REG_ADDR_W-1:0] instrout_1511
);

    opcode_t               opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [IMM_W-1:0]      imm;

    assign opcode = IF_ID_instr[31:26];
    assign rs     = IF_ID_instr[25:21];
    assign rt     = IF_ID_instr[20:16];
    assign rd     = IF_ID_instr[15:11];
    assign imm    = IF_ID_instr[15:0];

    logic [DATA_W-1:0] rdata1_c;
    logic [DATA_W-1:0] rdata2_c;

    id_regfile #(
        .DW    (DATA_W),
        .AW    (REG_ADDR_W),
        .DEPTH (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (MEM_WB_regwrite),
        .waddr    (MEM_WB_rd),
        .wdata    (WB_mux5_writedata),
        .raddr1   (rs),
        .raddr2   (rt),
        .rdata1_c (rdata1_c),
        .rdata2_c (rdata2_c)
    );

    wb_ctl_t           wb_d;
    m_ctl_t            m_d;
    logic              regdst_d;
    logic              alusrc_d;
    aluop_t            aluop_d;
    logic [DATA_W-1:0] sext_d;

    // Control decode; unknown opcodes become a bubble
    always_comb begin
        wb_d     = '0;
        m_d      = '0;
        regdst_d = 1'b0;
        alusrc_d = 1'b0;
        aluop_d  = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                regdst_d    = 1'b1;
                aluop_d     = ALUOP_FUNCT;
                wb_d.regwrite = 1'b1;
            end
            OP_LW: begin
                alusrc_d      = 1'b1;
                wb_d.regwrite = 1'b1;
                wb_d.memtoreg = 1'b1;
                m_d.memread   = 1'b1;
            end
            OP_SW: begin
                alusrc_d     = 1'b1;
                m_d.memwrite = 1'b1;
            end
            OP_BEQ: begin
                aluop_d    = ALUOP_SUB;
                m_d.branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Sign extension of imm16
    assign sext_d = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ctlout     <= '0;
            m_ctlout      <= '0;
            regdst        <= 1'b0;
            alusrc        <= 1'b0;
            aluop         <= '0;
            npcout        <= '0;
            rdata1out     <= '0;
            rdata2out     <= '0;
            s_extendout   <= '0;
            instrout_2016 <= '0;
            instrout_1511 <= '0;
        end else begin
            wb_ctlout     <= wb_d;
            m_ctlout      <= m_d;
            regdst        <= regdst_d;
            alusrc        <= alusrc_d;
            aluop         <= aluop_d;
            npcout        <= IF_ID_npc;
            rdata1out     <= rdata1_c;
            rdata2out     <= rdata2_c;
            s_extendout   <= sext_d;
            instrout_2016 <= rt;
            instrout_1511 <= rd;
        end
    end

endmodule

// File: tb/tb_idecode_stage.sv
// Self-checking bench for idecode_stage: reset checks, a table of directed
// vectors, and hand sequences for write-through and mid-run reset.
module tb_idecode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;
    logic [31:0] WB_mux5_writedata;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npcout;
    logic [31:0] rdata1out;
    logic [31:0] rdata2out;
    logic [31:0] s_extendout;
    logic [4:0]  instrout_2016;
    logic [4:0]  instrout_1511;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idecode_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .IF_ID_instr       (IF_ID_instr),
        .IF_ID_npc         (IF_ID_npc),
        .MEM_WB_rd         (MEM_WB_rd),
        .MEM_WB_regwrite   (MEM_WB_regwrite),
        .WB_mux5_writedata (WB_mux5_writedata),
        .wb_ctlout         (wb_ctlout),
        .m_ctlout          (m_ctlout),
        .regdst            (regdst),
        .alusrc            (alusrc),
        .aluop             (aluop),
        .npcout            (npcout),
        .rdata1out         (rdata1out),
        .rdata2out         (rdata2out),
        .s_extendout       (s_extendout),
        .instrout_2016     (instrout_2016),
        .instrout_1511     (instrout_1511)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  e_wb;
        logic [2:0]  e_m;
        logic        e_regdst;
        logic        e_alusrc;
        logic [1:0]  e_aluop;
        logic [31:0] e_npc;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic [31:0] e_sext;
        logic [4:0]  e_2016;
        logic [4:0]  e_1511;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] npc,
                         input logic [4:0] rd, input logic we, input logic [31:0] wd);
        IF_ID_instr       = instr;
        IF_ID_npc         = npc;
        MEM_WB_rd         = rd;
        MEM_WB_regwrite   = we;
        WB_mux5_writedata = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({wb_ctlout, m_ctlout, regdst, alusrc, aluop}), 32'h0);
        check({tag, "_npc"}, npcout, 32'h0);
        check({tag, "_rd1"}, rdata1out, 32'h0);
        check({tag, "_rd2"}, rdata2out, 32'h0);
        check({tag, "_sext"}, s_extendout, 32'h0);
        check({tag, "_fld"}, 32'({instrout_2016, instrout_1511}), 32'h0);
    endtask

    logic [31:0] exp_bypass;

    initial begin
        // instr, npc, rd, we, wdata | wb, m, regdst, alusrc, aluop, npc, r1, r2, sext, 2016, 1511
        vecs[0] = '{32'hFC000000, 32'h0,  5'd5, 1'b1, 32'hDEADBEEF,
                    2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'h0,  32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
        vecs[1] = '{32'h00A50820, 32'h4,  5'd2, 1'b1, 32'h00001000,
                    2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h4,  32'hDEADBEEF, 32'hDEADBEEF,
                    32'h00000820, 5'd5, 5'd1};
        vecs[2] = '{32'hFC000000, 32'h8,  5'd1, 1'b1, 32'h11111111,
                    2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'h8,  32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
        vecs[3] = '{32'h8C22FFFC, 32'hC,  5'd0, 1'b0, 32'h0,
                    2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'hC,  32'h11111111, 32'h00001000,
                    32'hFFFFFFFC, 5'd2, 5'd31};
        vecs[4] = '{32'hAC220010, 32'h10, 5'd0, 1'b0, 32'h0,
                    2'b00, 3'b001, 1'b0, 1'b1, 2'b00, 32'h10, 32'h11111111, 32'h00001000,
                    32'h00000010, 5'd2, 5'd0};
        vecs[5] = '{32'h10220003, 32'h40, 5'd0, 1'b1, 32'h00001234,
                    2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h40, 32'h11111111, 32'h00001000,
                    32'h00000003, 5'd2, 5'd0};
        vecs[6] = '{32'h00000000, 32'h44, 5'd0, 1'b0, 32'h0,
                    2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h44, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
        vecs[7] = '{32'h8C228000, 32'h48, 5'd0, 1'b0, 32'h0,
                    2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h48, 32'h11111111, 32'h00001000,
                    32'hFFFF8000, 5'd2, 5'd16};
        vecs[8] = '{32'hAC227FFF, 32'h4C, 5'd0, 1'b0, 32'h0,
                    2'b00, 3'b001, 1'b0, 1'b1, 2'b00, 32'h4C, 32'h11111111, 32'h00001000,
                    32'h00007FFF, 5'd2, 5'd15};

        // Reset with random inputs, clock running
        rst_n = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1, $urandom);
            step();
        end
        check_all_zero("reset");

        drive(32'hFC000000, 32'h0, 5'd0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #2;
        check_all_zero("post_release");

        // Every register reads 0 after reset
        for (int i = 1; i < 32; i++) begin
            drive({6'h00, 5'(i), 5'(i), 16'h0}, 32'h0, 5'd0, 1'b0, 32'h0);
            step();
            check($sformatf("rf_clear_r%0d_a", i), rdata1out, 32'h0);
            check($sformatf("rf_clear_r%0d_b", i), rdata2out, 32'h0);
        end

        // Directed vector table
        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].instr, vecs[v].npc, vecs[v].rd, vecs[v].we, vecs[v].wdata);
            step();
            check($sformatf("v%0d_wb", v),     32'(wb_ctlout),     32'(vecs[v].e_wb));
            check($sformatf("v%0d_m", v),      32'(m_ctlout),      32'(vecs[v].e_m));
            check($sformatf("v%0d_regdst", v), 32'(regdst),        32'(vecs[v].e_regdst));
            check($sformatf("v%0d_alusrc", v), 32'(alusrc),        32'(vecs[v].e_alusrc));
            check($sformatf("v%0d_aluop", v),  32'(aluop),         32'(vecs[v].e_aluop));
            check($sformatf("v%0d_npc", v),    npcout,             vecs[v].e_npc);
            check($sformatf("v%0d_rd1", v),    rdata1out,          vecs[v].e_r1);
            check($sformatf("v%0d_rd2", v),    rdata2out,          vecs[v].e_r2);
            check($sformatf("v%0d_sext", v),   s_extendout,        vecs[v].e_sext);
            check($sformatf("v%0d_2016", v),   32'(instrout_2016), 32'(vecs[v].e_2016));
            check($sformatf("v%0d_1511", v),   32'(instrout_1511), 32'(vecs[v].e_1511));
        end

        // Same-cycle write and read of R3
        drive(32'hFC000000, 32'h0, 5'd3, 1'b1, 32'h5);
        step();
        drive(32'h00630000, 32'h0, 5'd3, 1'b1, 32'h7);
        step();
`ifdef IDECODE_RF_BYPASS_EN
        exp_bypass = 32'h7;
`else
        exp_bypass = 32'h5;
`endif
        check("same_cycle_rd1", rdata1out, exp_bypass);
        check("same_cycle_rd2", rdata2out, exp_bypass);
        drive(32'h00630000, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        check("after_write_rd1", rdata1out, 32'h7);

        // Mid-run reset clears ID/EX immediately and the register file
        drive(32'h00A50820, 32'h50, 5'd0, 1'b0, 32'h0);
        step();
        check("pre_reset_rd1", rdata1out, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        step();
        rst_n = 1'b1;
        drive(32'h00A50820, 32'h50, 5'd0, 1'b0, 32'h0);
        step();
        check("rf_after_reset_rd1", rdata1out, 32'h0);
        check("rf_after_reset_rd2", rdata2out, 32'h0);
        check("rf_after_reset_npc", npcout, 32'h50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
